// File: rtl/stack_pop_sequencer_if.sv
// Stack read port shared between the pop sequencer (master) and the data memory (slave).
interface stack_pop_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/stack_pop_sequencer.sv
// RET/RTI pop sequencer: pops flags (RTI only) and the PC from the data stack, then commits PC, flags and SP together.
// Optional macro STACK_POP_BOUND_CHECK_EN aborts with a stack_fault pulse when a pop would read above STACK_TOP.
module stack_pop_sequencer #(
    parameter int DATA_W    = 16,
    parameter int PC_W      = 32,
    parameter int FLAG_W    = 4,
    parameter int ADDR_W    = 11,
    parameter int STACK_TOP = 2047
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_rti,
    input  logic [ADDR_W-1:0]    sp_in,
    stack_pop_sequencer_if.master mem,
    output logic                 stall,
    output logic                 busy,
    output logic [PC_W-1:0]      pc_out,
    output logic                 pc_load,
    output logic [FLAG_W-1:0]    flags_out,
    output logic                 flags_load,
    output logic [ADDR_W-1:0]    sp_out,
    output logic                 sp_load,
    output logic                 stack_fault
);

`ifdef STACK_POP_BOUND_CHECK_EN
    localparam bit BOUND_CHECK = 1'b1;
`else
    localparam bit BOUND_CHECK = 1'b0;
`endif

    localparam logic [ADDR_W:0] TOP_LIMIT = STACK_TOP[ADDR_W:0];

    typedef enum logic [2:0] {
        IDLE,
        POP_FLAGS,
        POP_PC_HI,
        POP_PC_LO,
        COMMIT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] sp_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [FLAG_W-1:0] flags_reg;
    logic              rti_reg;
    logic              busy_reg;
    logic [ADDR_W:0]   pop_addr;
    logic              pop_state;
    logic              over_top;
    logic              take;

    // One extra bit keeps the bound check from wrapping; the read address itself wraps.
    assign pop_addr  = {1'b0, sp_reg} + {{ADDR_W{1'b0}}, 1'b1};
    assign pop_state = (state == POP_FLAGS) || (state == POP_PC_HI) || (state == POP_PC_LO);
    assign over_top  = BOUND_CHECK && (pop_addr > TOP_LIMIT);
    assign take      = pop_state && !over_top && mem.mem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
        end else begin
            state    <= next_state;
            busy_reg <= (next_state != IDLE);
        end
    end

    always_comb begin
        next_state   = state;
        mem.mem_rd   = 1'b0;
        mem.mem_addr = '0;
        pc_load      = 1'b0;
        sp_load      = 1'b0;
        flags_load   = 1'b0;
        stack_fault  = 1'b0;
        if (pop_state) begin
            mem.mem_addr = pop_addr[ADDR_W-1:0];
            if (over_top) begin
                stack_fault = 1'b1;
                next_state  = IDLE;
            end else begin
                mem.mem_rd = 1'b1;
            end
        end
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = is_rti ? POP_FLAGS : POP_PC_HI;
                end
            end
            POP_FLAGS: if (take) next_state = POP_PC_HI;
            POP_PC_HI: if (take) next_state = POP_PC_LO;
            POP_PC_LO: if (take) next_state = COMMIT;
            COMMIT: begin
                pc_load    = 1'b1;
                sp_load    = 1'b1;
                flags_load = rti_reg;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Context is latched only from IDLE, so a start while busy cannot disturb a sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_reg    <= '0;
            pc_reg    <= '0;
            flags_reg <= '0;
            rti_reg   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                sp_reg  <= sp_in;
                rti_reg <= is_rti;
            end
            if (take) begin
                sp_reg <= pop_addr[ADDR_W-1:0];
                case (state)
                    POP_FLAGS: flags_reg              <= mem.mem_rdata[FLAG_W-1:0];
                    POP_PC_HI: pc_reg[PC_W-1:DATA_W] <= mem.mem_rdata;
                    POP_PC_LO: pc_reg[DATA_W-1:0]    <= mem.mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    assign stall     = busy_reg;
    assign busy      = busy_reg;
    assign pc_out    = pc_reg;
    assign flags_out = flags_reg;
    assign sp_out    = sp_reg;

endmodule

// File: tb/tb_stack_pop_sequencer.sv
// Self-checking bench for stack_pop_sequencer: memory responder with wait states plus a queue-based pop model.
module tb_stack_pop_sequencer;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 16;
    localparam int PC_W       = 32;
    localparam int FLAG_W     = 4;
    localparam int DEPTH      = 2048;
    localparam int STACK_TOP  = 2047;
    localparam int MAX_CYCLES = 40;

`ifdef STACK_POP_BOUND_CHECK_EN
    localparam bit BOUND_CHECK = 1'b1;
`else
    localparam bit BOUND_CHECK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              is_rti = 1'b0;
    logic [ADDR_W-1:0] sp_in = '0;
    logic              stall, busy, pc_load, flags_load, sp_load, stack_fault;
    logic [PC_W-1:0]   pc_out;
    logic [FLAG_W-1:0] flags_out;
    logic [ADDR_W-1:0] sp_out;

    stack_pop_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    stack_pop_sequencer #(
        .DATA_W(DATA_W), .PC_W(PC_W), .FLAG_W(FLAG_W), .ADDR_W(ADDR_W), .STACK_TOP(STACK_TOP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .is_rti(is_rti), .sp_in(sp_in),
        .mem(mem_if),
        .stall(stall), .busy(busy), .pc_out(pc_out), .pc_load(pc_load),
        .flags_out(flags_out), .flags_load(flags_load), .sp_out(sp_out),
        .sp_load(sp_load), .stack_fault(stack_fault)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem_model [DEPTH];
    int                assert_cnt = 0;
    int                fail_cnt = 0;

    bit                rd_pending = 1'b0;
    int                wait_cnt = 0;
    int                wait_target = 0;
    int                total_waits = 0;
    int                delay_addr = -1;
    int                delay_cycles = 0;
    int                rand_wait_max = 0;
    bit                stray_en = 1'b0;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic [ADDR_W-1:0] rd_log [$];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: inserts wait states per read and may throw stray acks while no read is pending.
    always @(negedge clk) begin
        if (mem_if.mem_rd) begin
            if (!rd_pending) begin
                rd_pending  = 1'b1;
                wait_cnt    = 0;
                pend_addr   = mem_if.mem_addr;
                wait_target = (int'(mem_if.mem_addr) == delay_addr) ? delay_cycles
                                                                      : int'($urandom_range(rand_wait_max, 0));
            end else begin
                check_output("addr_stable", 32'(mem_if.mem_addr), 32'(pend_addr));
            end
            if (wait_cnt >= wait_target) begin
                mem_if.mem_ack   = 1'b1;
                mem_if.mem_rdata = mem_model[mem_if.mem_addr];
                rd_pending       = 1'b0;
                rd_log.push_back(mem_if.mem_addr);
            end else begin
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = 16'($urandom);
                wait_cnt++;
                total_waits++;
            end
        end else begin
            rd_pending       = 1'b0;
            mem_if.mem_ack   = stray_en ? 1'($urandom_range(1, 0)) : 1'b0;
            mem_if.mem_rdata = 16'($urandom);
        end
    end

    task automatic apply_stimulus(input string tag, input bit rti, input logic [ADDR_W-1:0] sp, input bit hold_start);
        int                n;
        int                a;
        bit                exp_fault;
        logic [ADDR_W-1:0] exp_addr [$];
        logic [PC_W-1:0]   exp_pc;
        logic [FLAG_W-1:0] exp_flags;
        logic [ADDR_W-1:0] exp_sp;
        int                exp_end;
        int                end_seen, commit_cycle, fault_cycle;
        int                pc_cnt, sp_cnt, fl_cnt, fault_cnt, stall_cnt, rd_cycles, watch_cnt, busy_diff;
        logic [PC_W-1:0]   got_pc;
        logic [FLAG_W-1:0] got_flags;
        logic [ADDR_W-1:0] got_sp;

        // Model: pop n words from sp+1 upward, PC high word first, address wraps unless bounded.
        n         = rti ? 3 : 2;
        exp_fault = 1'b0;
        exp_addr.delete();
        for (int k = 1; k <= n; k++) begin
            a = int'(sp) + k;
            if (BOUND_CHECK && a > STACK_TOP) begin
                exp_fault = 1'b1;
                break;
            end
            exp_addr.push_back(ADDR_W'(a % DEPTH));
        end
        exp_pc    = '0;
        exp_flags = '0;
        if (!exp_fault) begin
            exp_pc = {mem_model[exp_addr[n-2]], mem_model[exp_addr[n-1]]};
            if (rti) exp_flags = mem_model[exp_addr[0]][FLAG_W-1:0];
        end
        exp_sp = ADDR_W'((int'(sp) + n) % DEPTH);

        end_seen = 0; commit_cycle = -1; fault_cycle = -1;
        pc_cnt = 0; sp_cnt = 0; fl_cnt = 0; fault_cnt = 0;
        stall_cnt = 0; rd_cycles = 0; watch_cnt = 0; busy_diff = 0;
        got_pc = '0; got_flags = '0; got_sp = '0;
        rd_log.delete();
        total_waits = 0;

        @(negedge clk);
        start  = 1'b1;
        is_rti = rti;
        sp_in  = sp;
        for (int c = 1; c <= MAX_CYCLES; c++) begin
            @(negedge clk);
            if (hold_start && c <= n + 1) begin
                start  = 1'b1;
                is_rti = 1'($urandom);
                sp_in  = ADDR_W'($urandom);
            end else begin
                start  = 1'b0;
                is_rti = 1'b0;
                sp_in  = '0;
            end
            if (stall !== busy) busy_diff++;
            if (stall) stall_cnt++;
            if (mem_if.mem_rd) rd_cycles++;
            if (mem_if.mem_rd && int'(mem_if.mem_addr) == delay_addr) watch_cnt++;
            if (sp_load) sp_cnt++;
            if (flags_load) fl_cnt++;
            if (pc_load) begin
                pc_cnt++;
                if (commit_cycle < 0) begin
                    commit_cycle = c;
                    got_pc       = pc_out;
                    got_flags    = flags_out;
                    got_sp       = sp_out;
                    if (end_seen == 0) end_seen = c;
                end
            end
            if (stack_fault) begin
                fault_cnt++;
                if (fault_cycle < 0) fault_cycle = c;
                if (end_seen == 0) end_seen = c;
            end
            if (end_seen > 0 && c >= end_seen + 3) break;
        end

        exp_end = exp_addr.size() + total_waits + 1;
        if (!exp_fault) begin
            check_output({tag, "_commit_cycle"}, 32'(commit_cycle), 32'(exp_end));
            check_output({tag, "_pc"}, got_pc, exp_pc);
            check_output({tag, "_sp"}, 32'(got_sp), 32'(exp_sp));
            if (rti) check_output({tag, "_flags"}, 32'(got_flags), 32'(exp_flags));
            check_output({tag, "_fault_cnt"}, 32'(fault_cnt), 32'd0);
        end else begin
            check_output({tag, "_fault_cycle"}, 32'(fault_cycle), 32'(exp_end));
            check_output({tag, "_fault_cnt"}, 32'(fault_cnt), 32'd1);
        end
        check_output({tag, "_pc_load_cnt"}, 32'(pc_cnt), exp_fault ? 32'd0 : 32'd1);
        check_output({tag, "_sp_load_cnt"}, 32'(sp_cnt), exp_fault ? 32'd0 : 32'd1);
        check_output({tag, "_flags_load_cnt"}, 32'(fl_cnt), (rti && !exp_fault) ? 32'd1 : 32'd0);
        check_output({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_end));
        check_output({tag, "_busy_eq_stall"}, 32'(busy_diff), 32'd0);
        check_output({tag, "_rd_cycles"}, 32'(rd_cycles), 32'(exp_addr.size() + total_waits));
        check_output({tag, "_rd_count"}, 32'(rd_log.size()), 32'(exp_addr.size()));
        if (rd_log.size() == exp_addr.size()) begin
            foreach (exp_addr[i]) check_output({tag, "_rd_addr"}, 32'(rd_log[i]), 32'(exp_addr[i]));
        end
        if (delay_addr >= 0) check_output({tag, "_addr_hold"}, 32'(watch_cnt), 32'(delay_cycles + 1));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 16'($urandom);
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;

        // Reset values while rst is held low.
        repeat (2) @(negedge clk);
        check_output("rst_stall", 32'(stall), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_strobes", {27'd0, pc_load, flags_load, sp_load, stack_fault, mem_if.mem_rd}, 32'd0);
        check_output("rst_pc", pc_out, 32'd0);
        check_output("rst_flags", 32'(flags_out), 32'd0);
        check_output("rst_sp", 32'(sp_out), 32'd0);
        check_output("rst_addr", 32'(mem_if.mem_addr), 32'd0);
        rst = 1'b1;

        mem_model[11'h101] = 16'h0000;
        mem_model[11'h102] = 16'h0040;
        apply_stimulus("ret_basic", 1'b0, 11'h100, 1'b0);
        check_output("ret_basic_pc_const", pc_out, 32'h0000_0040);

        mem_model[11'h201] = 16'h0005;
        mem_model[11'h202] = 16'h1234;
        mem_model[11'h203] = 16'h5678;
        apply_stimulus("rti_basic", 1'b1, 11'h200, 1'b0);
        check_output("rti_basic_pc_const", pc_out, 32'h1234_5678);

        delay_addr   = 11'h202;
        delay_cycles = 2;
        apply_stimulus("rti_delay", 1'b1, 11'h200, 1'b0);
        delay_addr   = -1;
        delay_cycles = 0;

        apply_stimulus("ret_wrap", 1'b0, 11'h7FF, 1'b0);
        apply_stimulus("rti_wrap", 1'b1, 11'h7FE, 1'b0);

        // Reset pulled low while the low PC word is being popped.
        @(negedge clk);
        start  = 1'b1;
        is_rti = 1'b1;
        sp_in  = 11'h300;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_output("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_output("abort_stall", 32'(stall), 32'd0);
        check_output("abort_strobes", {28'd0, pc_load, flags_load, sp_load, mem_if.mem_rd}, 32'd0);
        @(negedge clk);
        check_output("abort_next_stall", 32'(stall), 32'd0);
        check_output("abort_next_strobes", {29'd0, pc_load, flags_load, sp_load}, 32'd0);
        check_output("abort_pc_cleared", pc_out, 32'd0);
        rst = 1'b1;
        apply_stimulus("ret_after_abort", 1'b0, 11'h350, 1'b0);

        apply_stimulus("hold_start_rti", 1'b1, 11'h400, 1'b1);
        apply_stimulus("hold_start_ret", 1'b0, 11'h410, 1'b1);

        // Randomized sequences with wait states, stray acks and SPs near the top of the stack.
        rand_wait_max = 2;
        stray_en      = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bit                r;
            logic [ADDR_W-1:0] s;
            r = 1'($urandom);
            if ($urandom_range(3, 0) == 0) s = ADDR_W'(2044 + $urandom_range(3, 0));
            else                           s = ADDR_W'($urandom);
            apply_stimulus("random", r, s, 1'b0);
        end
        rand_wait_max = 0;
        stray_en      = 1'b0;

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/stack_pop_sequencer.md
Name: stack_pop_sequencer

Overview:
- Multi-cycle sequencer that restores the PC, and for RTI also the flags, from the data stack on RET/RTI.
- It is the pop-side counterpart of the push sequencer used by CALL/INT.
- Sits beside the memory stage and owns the memory read port while busy. Stalls the pipeline and issues one 16-bit stack read per pop state.
- Commits PC, flags and SP in a single cycle at the end.

Parameters:
DATA_W, 16, memory word width
PC_W, 32, PC width (PC_W = 2*DATA_W)
FLAG_W, 4, flags width, taken from the low bits of the flags word
ADDR_W, 11, stack address width
STACK_TOP, 2047, highest legal stack address (used only by the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle request from decode/memory stage
is_rti  in  1  sampled with start: 1 = RTI (flags+PC), 0 = RET (PC only)
sp_in  in  ADDR_W  current SP, sampled with start
mem_rd  out  1  stack read request
mem_addr  out  ADDR_W  read address
mem_rdata  in  DATA_W  read data, valid when mem_ack=1
mem_ack  in  1  read completion; may be high in the same cycle as mem_rd
stall  out  1  freeze fetch/decode
busy  out  1  sequencer not idle
pc_out  out  PC_W  restored PC
pc_load  out  1  one-cycle PC write strobe
flags_out  out  FLAG_W  restored flags
flags_load  out  1  one-cycle flags write strobe (RTI only)
sp_out  out  ADDR_W  final SP
sp_load  out  1  one-cycle SP write strobe
stack_fault  out  1  one-cycle fault strobe (optional feature only; else tied 0)

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; internal SP, PC and flags registers 0.
- States:
  - IDLE -> POP_FLAGS on start & is_rti.
  - IDLE -> POP_PC_HI on start & !is_rti.
  - POP_FLAGS -> POP_PC_HI, POP_PC_HI -> POP_PC_LO, POP_PC_LO -> COMMIT: each taken on mem_ack.
  - COMMIT -> IDLE unconditionally.
- Stack convention: SP points to the next free slot. Each pop reads M[sp+1], then sp <= sp+1. Address arithmetic is modulo 2^ADDR_W, so 2047+1 wraps to 0.
- In POP_* states:
  - mem_rd=1 and mem_addr=sp_reg+1, both held stable until mem_ack.
  - On ack, the word is captured and sp_reg increments.
- Captured words:
  - POP_FLAGS: flags_reg = mem_rdata[FLAG_W-1:0].
  - POP_PC_HI: pc_reg[31:16].
  - POP_PC_LO: pc_reg[15:0].
- COMMIT (single cycle):
  - pc_load=1 and sp_load=1.
  - flags_load=1 only if the latched is_rti=1.
  - pc_out, flags_out and sp_out are valid in this cycle and hold their values afterwards.
- stall = busy = (state != IDLE); both are registered outputs.
- Latency with zero-wait ack: RET commits 3 cycles after the start edge, RTI 4. Each ack wait-cycle adds 1.
- start while busy is ignored; is_rti and sp_in are sampled only in IDLE.
- mem_ack outside POP_* states is ignored.
- Reset mid-sequence aborts immediately: no load strobes, the pipeline sees stall=0.

Optional Feature:
- Macro: STACK_POP_BOUND_CHECK_EN.
- Defined:
  - Before each read, if sp_reg+1 > STACK_TOP (computed with ADDR_W+1 bits, so no wrap), raise stack_fault for one cycle, issue no mem_rd, and go to IDLE.
  - No pc_load, flags_load or sp_load is issued.
- Not defined: no check, addresses wrap, stack_fault is constant 0.

Test Plan:
- RET, sp_in=0x100, M[0x101]=0x0000, M[0x102]=0x0040, ack same cycle -> reads 0x101 then 0x102; pc_out=0x00000040, sp_out=0x102, pc_load 3 cycles after start, flags_load=0.
- RTI, sp_in=0x200, M[0x201]=0x0005, M[0x202]=0x1234, M[0x203]=0x5678 -> flags_out=0x5, pc_out=0x12345678, sp_out=0x203, all strobes together 4 cycles after start.
- RTI with mem_ack delayed 2 cycles on the PC_HI read -> mem_addr held at 0x202 for 3 cycles, commit at cycle 6, stall high for cycles 1-6.
- Wrap: RET, sp_in=0x7FF -> reads 0x000 then 0x001, sp_out=0x001 (macro undefined). With the macro and STACK_TOP=0x7FF -> stack_fault pulse, no mem_rd, no loads.
- rst driven low while in POP_PC_LO -> next cycle stall=0, no load strobes; a following RET completes normally.
- start re-asserted while busy -> ignored; exactly one commit occurs.
